// File: rtl/alu_multicycle_if.sv
// Issue/result bundle between the EX-stage ALU and its pipeline neighbours.
// The master presents ops. The slave is the ALU, which returns Result, HI/LO and status.
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             InValid;
  logic             InReady;
  logic [3:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             OutValid;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;
  logic             DivZero;

  modport master (
    output InValid, Op, A, B,
    input  InReady, OutValid, Result, Zero, HI, LO, DivZero
  );

  modport slave (
    input  InValid, Op, A, B,
    output InReady, OutValid, Result, Zero, HI, LO, DivZero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle EX ALU: registered single-cycle ops, iterative mult/div into HI/LO.
// Define ALU_DIV_EN to build the restoring divider; otherwise ops 13/14 complete in one cycle with DivZero set.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  alu_multicycle_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_NOR = 4'd4, OP_XOR = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7;
  localparam logic [3:0] OP_SRA = 4'd8, OP_SLT = 4'd9, OP_SLTU = 4'd10, OP_MULT = 4'd11;
  localparam logic [3:0] OP_MULTU = 4'd12, OP_DIV = 4'd13, OP_DIVU = 4'd14;
`ifdef ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  logic               accept, is_mul, is_div, sgn, go_mul, go_div, go_1c, last;
  logic [WIDTH-1:0]   a_mag, b_mag, alu_res;
  logic [CNT_W-2:0]   shamt;
  logic [WIDTH-1:0]   result_q, hi_q, lo_q;
  logic               zero_q, dz_q, neg;

  assign accept = bus.InValid && (state == IDLE);
  assign is_mul = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
  assign is_div = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
  assign sgn    = (bus.Op == OP_MULT) || (bus.Op == OP_DIV);
  assign go_mul = accept && is_mul;
  assign go_div = accept && is_div && DIV_EN;
  assign go_1c  = accept && !go_mul && !go_div;
  assign last   = (cnt == CNT_W'(1));
  // Signed mult/div run on magnitudes; the sign is restored on the final step.
  assign a_mag  = (sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign b_mag  = (sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
  assign shamt  = bus.A[CNT_W-2:0];

  always_comb begin
    alu_res = '0;
    case (bus.Op)
      OP_ADD:  alu_res = bus.A + bus.B;
      OP_SUB:  alu_res = bus.A - bus.B;
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_NOR:  alu_res = ~(bus.A | bus.B);
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_SLL:  alu_res = bus.B << shamt;
      OP_SRL:  alu_res = bus.B >> shamt;
      OP_SRA:  alu_res = $signed(bus.B) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (go_mul) state_nxt = MUL;
                else if (go_div) state_nxt = DIV;
                else if (go_1c) state_nxt = DONE;
      MUL, DIV: if (last) state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shift-add multiplier: {partial, multiplier} in one 2*WIDTH register.
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] macc, macc_nxt, prod;
  logic [WIDTH:0]     msum;
  assign msum     = {1'b0, macc[2*WIDTH-1:WIDTH]} + (macc[0] ? {1'b0, mcand} : '0);
  assign macc_nxt = {msum, macc[WIDTH-1:1]};
  assign prod     = neg ? -macc_nxt : macc_nxt;

`ifdef ALU_DIV_EN
  logic [WIDTH-1:0] dvsr, quo, rem, a_orig, quo_nxt, rem_nxt, div_lo, div_hi;
  logic [WIDTH:0]   dshift, ddiff;
  logic             rneg, dge;
  assign dshift  = {rem, quo[WIDTH-1]};
  assign ddiff   = dshift - {1'b0, dvsr};
  assign dge     = dshift >= {1'b0, dvsr};
  assign rem_nxt = dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], dge};

  always_comb begin
    div_lo = neg  ? -quo_nxt : quo_nxt;
    div_hi = rneg ? -rem_nxt : rem_nxt;
    if (dvsr == '0) begin
      div_lo = '1;
      div_hi = a_orig;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      dvsr <= '0; quo <= '0; rem <= '0; a_orig <= '0; rneg <= 1'b0;
    end else if (go_div) begin
      dvsr <= b_mag; quo <= a_mag; rem <= '0; a_orig <= bus.A;
      rneg <= sgn && bus.A[WIDTH-1];
    end else if (state == DIV) begin
      quo <= quo_nxt; rem <= rem_nxt;
    end
  end
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0; result_q <= '0; zero_q <= 1'b1; hi_q <= '0; lo_q <= '0;
      dz_q <= 1'b0; neg <= 1'b0; mcand <= '0; macc <= '0;
    end else begin
      if (go_mul || go_div) begin
        cnt <= CNT_W'(WIDTH);
        neg <= sgn && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
      end else if (state == MUL || state == DIV) begin
        cnt <= cnt - 1'b1;
      end
      if (go_mul) begin
        macc  <= {{WIDTH{1'b0}}, b_mag};
        mcand <= a_mag;
      end else if (state == MUL) begin
        macc <= macc_nxt;
      end
      // Without the divider, ops 13/14 flag DivZero and leave HI/LO alone.
      if (accept) dz_q <= !DIV_EN && is_div;
      if (go_1c) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end
      if (state == MUL && last) begin
        hi_q     <= prod[2*WIDTH-1:WIDTH];
        lo_q     <= prod[WIDTH-1:0];
        result_q <= prod[WIDTH-1:0];
        zero_q   <= (prod[WIDTH-1:0] == '0);
      end
`ifdef ALU_DIV_EN
      if (state == DIV && last) begin
        hi_q     <= div_hi;
        lo_q     <= div_lo;
        result_q <= div_lo;
        zero_q   <= (div_lo == '0);
        dz_q     <= (dvsr == '0);
      end
`endif
    end
  end

  assign bus.InReady  = (state == IDLE);
  assign bus.OutValid = (state == DONE);
  assign bus.Result   = result_q;
  assign bus.Zero     = zero_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;
  assign bus.DivZero  = dz_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle (WIDTH=32); expectations for ops 13/14 follow ALU_DIV_EN.
module tb_alu_multicycle;
  localparam int WIDTH = 32;
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, NOR_ = 4'd4;
  localparam logic [3:0] XOR_ = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8, SLT = 4'd9;
  localparam logic [3:0] SLTU = 4'd10, MULT = 4'd11, MULTU = 4'd12, DIV = 4'd13, DIVU = 4'd14;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  alu_multicycle_if #(.WIDTH(WIDTH)) bus ();
  alu_multicycle #(.WIDTH(WIDTH)) dut (.Clk(Clk), .Reset(Reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Presents one op once the unit is ready; returns cycles from presentation to OutValid
  // and whether InReady was ever seen high before completion.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output bit rdy_hi);
    int guard = 0;
    @(negedge Clk);
    while (!bus.InReady && guard < 100) begin @(negedge Clk); guard++; end
    bus.InValid = 1'b1; bus.Op = op; bus.A = a; bus.B = b;
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    lat = 1; rdy_hi = 1'b0;
    while (!bus.OutValid && lat < 200) begin
      if (bus.InReady) rdy_hi = 1'b1;
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; bus.InValid = 1'b0; bus.Op = '0; bus.A = '0; bus.B = '0;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++; if (bus.Result !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", bus.Result); end
    n_cmp++; if (bus.Zero !== 1'b1) begin n_err++; $display("FAIL reset_zero got %b want 1", bus.Zero); end
    n_cmp++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin n_err++; $display("FAIL reset_hilo got %h/%h want 0/0", bus.HI, bus.LO); end
    n_cmp++; if (bus.OutValid !== 1'b0 || bus.DivZero !== 1'b0) begin n_err++; $display("FAIL reset_flags got ov=%b dz=%b want 0/0", bus.OutValid, bus.DivZero); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    n_cmp++; if (bus.InReady !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", bus.InReady); end
  endtask

  task automatic test_reset_mid_mul;
    int lat; bit rdy; bit seen = 1'b0;
    run_op(MULT, 32'd3, 32'd7, lat, rdy);
    n_cmp++; if (bus.LO !== 32'd21) begin n_err++; $display("FAIL pre_reset_lo got %h want 15", bus.LO); end
    @(negedge Clk);
    bus.InValid = 1'b1; bus.Op = MULT; bus.A = 32'd5; bus.B = 32'd5;
    @(posedge Clk); #1; bus.InValid = 1'b0;
    repeat (9) @(posedge Clk);
    #1; Reset = 1'b0; #1;
    n_cmp++; if (bus.Result !== 32'h0 || bus.Zero !== 1'b1) begin n_err++; $display("FAIL midreset_result got %h z=%b want 0 z=1", bus.Result, bus.Zero); end
    n_cmp++; if (bus.HI !== 32'h0 || bus.LO !== 32'h0) begin n_err++; $display("FAIL midreset_hilo got %h/%h want 0/0", bus.HI, bus.LO); end
    n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL midreset_outvalid got %b want 0", bus.OutValid); end
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    n_cmp++; if (bus.InReady !== 1'b1) begin n_err++; $display("FAIL midreset_ready got %b want 1", bus.InReady); end
    repeat (40) begin @(posedge Clk); #1; if (bus.OutValid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_discard got outvalid=%b want 0", seen); end
  endtask

  task automatic test_mult;
    int lat; bit rdy;
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, lat, rdy);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL mult_latency got %0d want 33", lat); end
    n_cmp++; if (rdy !== 1'b0 || bus.InReady !== 1'b0) begin n_err++; $display("FAIL mult_ready got busy_rdy=%b done_rdy=%b want 0/0", rdy, bus.InReady); end
    n_cmp++; if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_hilo got %h/%h want ffffffff/ffffffeb", bus.HI, bus.LO); end
    n_cmp++; if (bus.Result !== 32'hFFFF_FFEB || bus.Zero !== 1'b0) begin n_err++; $display("FAIL mult_result got %h z=%b want ffffffeb z=0", bus.Result, bus.Zero); end
    @(posedge Clk); #1;
    n_cmp++; if (bus.OutValid !== 1'b0) begin n_err++; $display("FAIL mult_pulse got %b want 0", bus.OutValid); end
    run_op(MULTU, 32'hFFFF_FFFF, 32'd2, lat, rdy);
    n_cmp++; if (lat != 33) begin n_err++; $display("FAIL multu_latency got %0d want 33", lat); end
    n_cmp++; if (bus.HI !== 32'h1 || bus.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hilo got %h/%h want 00000001/fffffffe", bus.HI, bus.LO); end
  endtask

  task automatic test_single;
    logic [3:0]  ops [12] = '{ADD, SUB, SRA, SLTU, SLT, SLL, SRL, AND_, OR_, NOR_, XOR_, 4'd15};
    logic [31:0] as  [12] = '{32'h7FFF_FFFF, 32'd5, 32'd4, 32'd1, 32'hFFFF_FFFF, 32'd4, 32'h24,
                             32'hF0F0, 32'hF000, 32'h0, 32'hFFFF, 32'd5};
    logic [31:0] bs  [12] = '{32'd1, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000,
                             32'hFF00, 32'h000F, 32'h0, 32'h0F0F, 32'd5};
    logic [31:0] ex  [12] = '{32'h8000_0000, 32'h0, 32'hF800_0000, 32'd1, 32'd1, 32'h10, 32'h0800_0000,
                             32'hF000, 32'hF00F, 32'hFFFF_FFFF, 32'hF0F0, 32'h0};
    int lat; bit rdy;
    for (int i = 0; i < 12; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rdy);
      n_cmp++; if (bus.Result !== ex[i] || bus.Zero !== (ex[i] == 32'h0)) begin
        n_err++; $display("FAIL single_op%0d got %h z=%b want %h z=%b", ops[i], bus.Result, bus.Zero, ex[i], ex[i] == 32'h0);
      end
      n_cmp++; if (lat != 1) begin n_err++; $display("FAIL single_latency op%0d got %0d want 1", ops[i], lat); end
    end
    n_cmp++; if (bus.HI !== 32'h1 || bus.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL single_hilo_kept got %h/%h want 00000001/fffffffe", bus.HI, bus.LO); end
    @(posedge Clk); #1;
    n_cmp++; if (bus.Result !== 32'h0 || bus.OutValid !== 1'b0) begin n_err++; $display("FAIL result_hold got %h ov=%b want 0 ov=0", bus.Result, bus.OutValid); end
  endtask

  task automatic test_div;
    int lat; bit rdy;
`ifdef ALU_DIV_EN
    logic [3:0]  ops [5] = '{DIV, DIVU, DIV, DIV, DIV};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'd100, 32'd9, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] bs  [5] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] elo [5] = '{32'hFFFF_FFFD, 32'd14, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'd2, 32'd9, 32'h0, 32'hFFFF_FFF9};
    logic        edz [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], lat, rdy);
      n_cmp++; if (lat != 33) begin n_err++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
      n_cmp++; if (bus.LO !== elo[i] || bus.HI !== ehi[i] || bus.Result !== elo[i]) begin
        n_err++; $display("FAIL div%0d_hilo got lo=%h hi=%h res=%h want lo=%h hi=%h", i, bus.LO, bus.HI, bus.Result, elo[i], ehi[i]);
      end
      n_cmp++; if (bus.DivZero !== edz[i]) begin n_err++; $display("FAIL div%0d_divzero got %b want %b", i, bus.DivZero, edz[i]); end
      if (i == 2) begin
        run_op(ADD, 32'd1, 32'd1, lat, rdy);
        n_cmp++; if (bus.DivZero !== 1'b0 || bus.Result !== 32'd2) begin n_err++; $display("FAIL divzero_clear got dz=%b res=%h want 0/2", bus.DivZero, bus.Result); end
      end
    end
`else
    run_op(DIVU, 32'd100, 32'd7, lat, rdy);
    n_cmp++; if (lat != 1) begin n_err++; $display("FAIL nodiv_latency got %0d want 1", lat); end
    n_cmp++; if (bus.Result !== 32'h0 || bus.Zero !== 1'b1 || bus.DivZero !== 1'b1) begin
      n_err++; $display("FAIL nodiv_result got res=%h z=%b dz=%b want 0/1/1", bus.Result, bus.Zero, bus.DivZero);
    end
    n_cmp++; if (bus.HI !== 32'h1 || bus.LO !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL nodiv_hilo got %h/%h want 00000001/fffffffe", bus.HI, bus.LO); end
    run_op(ADD, 32'd1, 32'd1, lat, rdy);
    n_cmp++; if (bus.DivZero !== 1'b0) begin n_err++; $display("FAIL nodiv_clear got %b want 0", bus.DivZero); end
`endif
  endtask

  task automatic test_back_to_back;
    int lat = 1; bit rdy = 1'b0; int guard = 0;
`ifdef ALU_DIV_EN
    logic [3:0] lop = DIVU; logic [31:0] la = 32'd100, lb = 32'd7, elo = 32'd14, ehi = 32'd2;
`else
    logic [3:0] lop = MULTU; logic [31:0] la = 32'd6, lb = 32'd7, elo = 32'd42, ehi = 32'd0;
`endif
    @(negedge Clk);
    while (!bus.InReady && guard < 100) begin @(negedge Clk); guard++; end
    bus.InValid = 1'b1; bus.Op = lop; bus.A = la; bus.B = lb;
    @(posedge Clk); #1;
    bus.Op = ADD; bus.A = 32'd1; bus.B = 32'd2;
    while (!bus.OutValid && lat < 200) begin
      if (bus.InReady) rdy = 1'b1;
      @(posedge Clk); #1;
      lat++;
    end
    n_cmp++; if (lat != 33 || rdy !== 1'b0) begin n_err++; $display("FAIL b2b_long got lat=%0d rdy=%b want 33/0", lat, rdy); end
    n_cmp++; if (bus.Result !== elo || bus.InReady !== 1'b0) begin n_err++; $display("FAIL b2b_long_result got %h rdy=%b want %h rdy=0", bus.Result, bus.InReady, elo); end
    @(posedge Clk); #1;
    n_cmp++; if (bus.OutValid !== 1'b0 || bus.InReady !== 1'b1) begin n_err++; $display("FAIL b2b_idle got ov=%b rdy=%b want 0/1", bus.OutValid, bus.InReady); end
    @(posedge Clk); #1;
    bus.InValid = 1'b0;
    n_cmp++; if (bus.OutValid !== 1'b1 || bus.Result !== 32'd3) begin n_err++; $display("FAIL b2b_add got ov=%b res=%h want 1/3", bus.OutValid, bus.Result); end
    n_cmp++; if (bus.HI !== ehi || bus.LO !== elo) begin n_err++; $display("FAIL b2b_hilo got %h/%h want %h/%h", bus.HI, bus.LO, ehi, elo); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mul();
    test_mult();
    test_single();
    test_div();
    test_back_to_back();
    repeat (2) @(posedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
